// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, input-port FSM states and default widths.
package core_pkg;

    localparam logic [3:0] OPCODE_INPUT   = 4'b1101;
    localparam int         DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IP_IDLE         = 2'd0,
        IP_WAIT_PRESS   = 2'd1,
        IP_WAIT_RELEASE = 2'd2,
        IP_DONE         = 2'd3
    } ip_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Confirm-switch front end: 2-flop synchronizer, stability counter and
// registered press/release pulses aligned with the debounced level change.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic switch,
    output logic sw_db,
    output logic press_evt,
    output logic release_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          settle;

    // The sample that brings the count to DEBOUNCE_CYCLES flips the level.
    assign settle = (sync2 != sw_db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            cnt         <= '0;
            sw_db       <= 1'b0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            sync1       <= switch;
            sync2       <= sync1;
            press_evt   <= settle & ~sw_db;
            release_evt <= settle & sw_db;
            if (sync2 == sw_db) begin
                cnt <= '0;
            end else if (settle) begin
                cnt   <= '0;
                sw_db <= ~sw_db;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_port_controller.sv
// Responder for the INPUT instruction: stalls the core through a debounced
// press/release handshake, then presents the latched switch word for one cycle.
//
// state           | meaning
// IP_IDLE         | no transaction; req starts one (lock follows req)
// IP_WAIT_PRESS   | stalled, waiting for a fresh debounced press
// IP_WAIT_RELEASE | word captured, waiting for debounced release
// IP_DONE         | in_valid high, lock low so the INPUT retires
module input_port_controller
    import core_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DATA_W          = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              switch,
    input  logic [DATA_W-1:0] sw_data,
    output logic              lock,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              busy
);

    ip_state_t         state;
    ip_state_t         state_next;
    logic              capture;
    logic [DATA_W-1:0] sd_sync1;
    logic [DATA_W-1:0] sd_sync2;
    logic              sw_db;
    logic              press_evt;
    logic              release_evt;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk        (clk),
        .reset      (reset),
        .switch     (switch),
        .sw_db      (sw_db),
        .press_evt  (press_evt),
        .release_evt(release_evt)
    );

    // Data switches are only sampled at a press, long after they settle,
    // so a plain per-bit synchronizer is enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_sync1 <= '0;
            sd_sync2 <= '0;
        end else begin
            sd_sync1 <= sw_data;
            sd_sync2 <= sd_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        in_valid   = 1'b0;
        lock       = 1'b0;
        case (state)
            IP_IDLE: begin
                lock = req;
                if (req) begin
                    state_next = IP_WAIT_PRESS;
                end
            end
            IP_WAIT_PRESS: begin
                lock = 1'b1;
                if (press_evt) begin
                    capture    = 1'b1;
                    state_next = IP_WAIT_RELEASE;
                end
            end
            IP_WAIT_RELEASE: begin
                lock = 1'b1;
                if (release_evt) begin
                    state_next = IP_DONE;
                end
            end
            IP_DONE: begin
                in_valid   = 1'b1;
                state_next = IP_IDLE;
            end
            default: begin
                state_next = IP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_data <= '0;
        end else if (capture) begin
            in_data <= sd_sync2;
        end
    end

    assign busy = (state != IP_IDLE);

endmodule

// File: tb/tb_input_port_controller.sv
// Directed bench for input_port_controller with DEBOUNCE_CYCLES=4, DATA_W=16.
module tb_input_port_controller;
    import core_pkg::*;

    logic        clk;
    logic        reset;
    logic        req;
    logic        switch;
    logic [15:0] sw_data;
    logic        lock;
    logic [15:0] in_data;
    logic        in_valid;
    logic        busy;

    int checks;
    int errors;

    input_port_controller #(
        .DEBOUNCE_CYCLES(4),
        .DATA_W(16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .switch  (switch),
        .sw_data (sw_data),
        .lock    (lock),
        .in_data (in_data),
        .in_valid(in_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset  = 1'b1;
        req    = 1'b0;
        switch = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // Bounded wait for in_valid; seen reports whether it arrived.
    task automatic wait_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (in_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (lock !== 1'b0 || in_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: lock=%b in_valid=%b busy=%b expected 0 0 0", lock, in_valid, busy);
        end
        checks++;
        if (in_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_in_data: got %h expected 0000", in_data);
        end
        checks++;
        if (dut.state !== IP_IDLE || dut.u_db.sw_db !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d sw_db=%b expected 0 0", dut.state, dut.u_db.sw_db);
        end
        reset_dut();
    endtask

    task automatic test_basic();
        reset_dut();
        sw_data = 16'hBEEF;
        repeat (3) tick();
        req = 1'b1;
        #1;
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("FAIL basic_lock_on_req: got %b expected 1", lock);
        end
        tick();
        req = 1'b0;
        checks++;
        if (dut.state !== IP_WAIT_PRESS || lock !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_wait_press: state=%0d lock=%b busy=%b expected 1 1 1", dut.state, lock, busy);
        end
        switch = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (lock !== 1'b1 || in_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_press_phase k=%0d: lock=%b in_valid=%b expected 1 0", k, lock, in_valid);
            end
            if (k == 5) begin
                checks++;
                if (dut.u_db.sw_db !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_debounce_early: sw_db=%b expected 0", dut.u_db.sw_db);
                end
            end
            if (k == 6) begin
                checks++;
                if (dut.u_db.sw_db !== 1'b1 || dut.u_db.press_evt !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_press_evt: sw_db=%b press_evt=%b expected 1 1", dut.u_db.sw_db, dut.u_db.press_evt);
                end
            end
            if (k == 7) begin
                checks++;
                if (in_data !== 16'hBEEF || dut.state !== IP_WAIT_RELEASE) begin
                    errors++;
                    $display("FAIL basic_capture: in_data=%h state=%0d expected BEEF 2", in_data, dut.state);
                end
            end
        end
        switch = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 7) begin
                checks++;
                if (in_valid !== 1'b0 || lock !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_release_phase k=%0d: in_valid=%b lock=%b expected 0 1", k, in_valid, lock);
                end
            end
        end
        checks++;
        if (in_valid !== 1'b1 || lock !== 1'b0 || in_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL basic_done: in_valid=%b lock=%b in_data=%h expected 1 0 BEEF", in_valid, lock, in_data);
        end
        tick();
        checks++;
        if (in_valid !== 1'b0 || busy !== 1'b0 || lock !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: in_valid=%b busy=%b lock=%b expected 0 0 0", in_valid, busy, lock);
        end
    endtask

    task automatic test_glitch();
        bit saw_press;
        reset_dut();
        req = 1'b1;
        tick();
        req    = 1'b0;
        switch = 1'b1;
        repeat (3) tick();
        switch    = 1'b0;
        saw_press = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dut.u_db.press_evt === 1'b1) saw_press = 1'b1;
        end
        checks++;
        if (saw_press !== 1'b0 || dut.u_db.sw_db !== 1'b0) begin
            errors++;
            $display("FAIL glitch_press: press_seen=%b sw_db=%b expected 0 0", saw_press, dut.u_db.sw_db);
        end
        checks++;
        if (dut.state !== IP_WAIT_PRESS || lock !== 1'b1) begin
            errors++;
            $display("FAIL glitch_state: state=%0d lock=%b expected 1 1", dut.state, lock);
        end
    endtask

    task automatic test_stale_press();
        bit seen;
        reset_dut();
        sw_data = 16'h1111;
        switch  = 1'b1;
        repeat (10) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (10) tick();
        checks++;
        if (dut.state !== IP_WAIT_PRESS || in_data !== 16'h0000) begin
            errors++;
            $display("FAIL stale_no_capture: state=%0d in_data=%h expected 1 0000", dut.state, in_data);
        end
        switch = 1'b0;
        repeat (10) tick();
        checks++;
        if (dut.state !== IP_WAIT_PRESS || dut.u_db.sw_db !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_release: state=%0d sw_db=%b expected 1 0", dut.state, dut.u_db.sw_db);
        end
        sw_data = 16'h2222;
        repeat (3) tick();
        switch = 1'b1;
        repeat (10) tick();
        checks++;
        if (dut.state !== IP_WAIT_RELEASE || in_data !== 16'h2222) begin
            errors++;
            $display("FAIL stale_second_press: state=%0d in_data=%h expected 2 2222", dut.state, in_data);
        end
        switch = 1'b0;
        wait_valid(20, seen);
        checks++;
        if (seen !== 1'b1 || in_data !== 16'h2222) begin
            errors++;
            $display("FAIL stale_done: valid_seen=%b in_data=%h expected 1 2222", seen, in_data);
        end
    endtask

    task automatic test_data_stability();
        bit seen;
        reset_dut();
        sw_data = 16'h1234;
        repeat (3) tick();
        req = 1'b1;
        tick();
        req    = 1'b0;
        switch = 1'b1;
        repeat (10) tick();
        sw_data = 16'h5678;
        repeat (5) tick();
        switch = 1'b0;
        wait_valid(20, seen);
        checks++;
        if (seen !== 1'b1 || in_data !== 16'h1234) begin
            errors++;
            $display("FAIL data_stability: valid_seen=%b in_data=%h expected 1 1234", seen, in_data);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        reset_dut();
        sw_data = 16'hABCD;
        repeat (3) tick();
        req = 1'b1;
        tick();
        req    = 1'b0;
        switch = 1'b1;
        repeat (10) tick();
        checks++;
        if (dut.state !== IP_WAIT_RELEASE || in_data !== 16'hABCD) begin
            errors++;
            $display("FAIL rstmid_setup: state=%0d in_data=%h expected 2 ABCD", dut.state, in_data);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (lock !== 1'b0 || in_data !== 16'h0000 || dut.state !== IP_IDLE || in_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: lock=%b in_data=%h state=%0d in_valid=%b expected 0 0000 0 0",
                     lock, in_data, dut.state, in_valid);
        end
        switch = 1'b0;
        repeat (2) tick();
        reset     = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (in_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_valid: valid_seen=%b busy=%b expected 0 0", saw_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        reset_dut();
        sw_data = 16'h00A1;
        repeat (3) tick();
        req = 1'b1;
        tick();
        switch = 1'b1;
        repeat (10) tick();
        switch = 1'b0;
        wait_valid(20, seen);
        checks++;
        if (seen !== 1'b1 || lock !== 1'b0 || in_data !== 16'h00A1) begin
            errors++;
            $display("FAIL b2b_first_done: valid_seen=%b lock=%b in_data=%h expected 1 0 00A1", seen, lock, in_data);
        end
        tick();
        checks++;
        if (dut.state !== IP_IDLE || lock !== 1'b1 || in_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: state=%0d lock=%b in_valid=%b expected 0 1 0", dut.state, lock, in_valid);
        end
        tick();
        req = 1'b0;
        repeat (10) tick();
        checks++;
        if (dut.state !== IP_WAIT_PRESS || lock !== 1'b1 || in_data !== 16'h00A1) begin
            errors++;
            $display("FAIL b2b_needs_press: state=%0d lock=%b in_data=%h expected 1 1 00A1", dut.state, lock, in_data);
        end
        sw_data = 16'h00B2;
        repeat (3) tick();
        switch = 1'b1;
        repeat (10) tick();
        switch = 1'b0;
        wait_valid(20, seen);
        checks++;
        if (seen !== 1'b1 || in_data !== 16'h00B2) begin
            errors++;
            $display("FAIL b2b_second_done: valid_seen=%b in_data=%h expected 1 00B2", seen, in_data);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        req     = 1'b0;
        switch  = 1'b0;
        sw_data = 16'h0000;
        test_reset();
        test_basic();
        test_glitch();
        test_stale_press();
        test_data_stability();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
